simple_spi_slave: RTL and testbench

SIMPLE_SPI_SLAVE -- requirements
Module: simple_spi_slave

---
 rtl/simple_spi_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_simple_spi_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_spi_slave.sv
// ============================================================================
// simple_spi_slave : SPI mode-0 slave (8-bit, MSB first) with Wishbone regs
// Revision: 1.0
// ============================================================================
`default_nettype none

module simple_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [1:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       inta_o,
    input  logic       sck_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;

    logic       r_ack;
    logic       r_en;
    logic       r_ie;
    logic       r_rxv;
    logic       r_txf;
    logic       r_ovr;
    logic       r_reload;
    logic [7:0] r_rxdata;
    logic [7:0] r_tx;
    logic [7:0] r_shift;
    logic [7:0] r_rx_sh;
    logic [2:0] r_cnt;

    logic       w_sck;
    logic       w_ss_n;
    logic       w_mosi;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_ss_fall;
    logic       w_acc;
    logic       w_rx_rd;
    logic       w_tx_wr;
    logic       w_ctrl_wr;
    logic       w_ovr_clr;
    logic       w_enter;
    logic       w_stay;
    logic       w_rise;
    logic       w_fall;
    logic       w_wrap;
    logic       w_load;
    logic [7:0] w_byte;
    logic [7:0] w_rdata;

    // Synchronizers plus one extra stage for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_n     = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_ss_fall  = ~w_ss_n & r_ss_d;

    // Side effects use the ack cycle, so the master's qualifiers are still valid
    assign w_acc     = r_ack & cyc_i & stb_i;
    assign w_rx_rd   = w_acc & ~we_i & (adr_i == 2'd2);
    assign w_tx_wr   = w_acc & we_i & (adr_i == 2'd3);
    assign w_ctrl_wr = w_acc & we_i & (adr_i == 2'd0);
    assign w_ovr_clr = w_acc & we_i & (adr_i == 2'd1) & dat_i[2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= cyc_i & stb_i & ~r_ack;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (r_en && w_ss_fall) w_next = ST_XFER;
            ST_XFER: if (!r_en || w_ss_n)   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_enter = (r_state == ST_IDLE) && (w_next == ST_XFER);
    assign w_stay  = (r_state == ST_XFER) && (w_next == ST_XFER);
    assign w_rise  = w_stay & w_sck_rise;
    assign w_fall  = w_stay & w_sck_fall;
    assign w_wrap  = w_rise & (r_cnt == 3'd7);
    assign w_load  = w_enter | (w_fall & r_reload);
    assign w_byte  = {r_rx_sh[6:0], w_mosi};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
            r_rxv    <= 1'b0;
            r_txf    <= 1'b0;
            r_ovr    <= 1'b0;
            r_reload <= 1'b0;
            r_rxdata <= 8'h00;
            r_tx     <= 8'h00;
            r_shift  <= 8'h00;
            r_rx_sh  <= 8'h00;
            r_cnt    <= 3'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_en <= dat_i[0];
                r_ie <= dat_i[1];
            end

            if (w_load) begin
                r_shift <= r_txf ? r_tx : 8'h00;
            end else if (w_fall) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end

            if (w_tx_wr) begin
                r_tx  <= dat_i;
                r_txf <= 1'b1;
            end else if (w_load) begin
                r_txf <= 1'b0;
            end

            if (w_enter) begin
                r_cnt <= 3'd0;
            end else if (w_rise) begin
                r_cnt <= r_cnt + 3'd1;
            end

            if (w_rise) begin
                r_rx_sh <= w_byte;
            end

            if (w_enter || w_fall) begin
                r_reload <= 1'b0;
            end else if (w_wrap) begin
                r_reload <= 1'b1;
            end

            // A same-cycle RXDATA read frees the slot, so the new byte is kept
            if (w_wrap && (!r_rxv || w_rx_rd)) begin
                r_rxdata <= w_byte;
            end

            if (w_wrap) begin
                r_rxv <= 1'b1;
            end else if (w_rx_rd) begin
                r_rxv <= 1'b0;
            end

            if (w_wrap && r_rxv && !w_rx_rd) begin
                r_ovr <= 1'b1;
            end else if (w_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (r_ack && !we_i) begin
            case (adr_i)
                2'd0:    w_rdata = {6'b0, r_ie, r_en};
                2'd1:    w_rdata = {4'b0, (r_state == ST_XFER), r_ovr, r_txf, r_rxv};
                2'd2:    w_rdata = r_rxdata;
                default: w_rdata = 8'h00;
            endcase
        end
    end

    assign dat_o  = w_rdata;
    assign ack_o  = r_ack;
    assign inta_o = r_ie & (r_rxv | r_ovr);
    assign miso_o = (r_state == ST_XFER) & r_shift[7];

endmodule

`default_nettype wire

// File: tb/tb_simple_spi_slave.sv
// ============================================================================
// tb_simple_spi_slave : directed, table-driven bench for simple_spi_slave
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simple_spi_slave;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [1:0] adr_i = 2'd0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o;
    logic       inta_o;
    logic       sck_i  = 1'b0;
    logic       ss_n_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] m_acc = 8'h00;

    simple_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .inta_o (inta_o),
        .sck_i  (sck_i),
        .ss_n_i (ss_n_i),
        .mosi_i (mosi_i),
        .miso_o (miso_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         do_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } frame_vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                             output logic [7:0] rd);
        int n;
        rd = 8'h00;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
        n = 0;
        @(negedge clk_i);
        while (!ack_o && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        if (!ack_o) begin
            chk("wb_ack_timeout", 8'h00, 8'h01);
        end else begin
            rd = dat_o;
            @(posedge clk_i);
            #1;
            chk("ack_single_cycle", {7'b0, ack_o}, 8'h00);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [7:0] wd);
        logic [7:0] rd;
        wb_access(1'b1, adr, wd, rd);
    endtask

    task automatic wb_read(input logic [1:0] adr, input logic [7:0] exp, input string name);
        logic [7:0] rd;
        wb_access(1'b0, adr, 8'h00, rd);
        chk(name, rd, exp);
    endtask

    // Master drives mosi while sck is low and samples miso on the rising edge
    task automatic spi_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            mosi_i = d[7-i];
            #80;
            sck_i = 1'b1;
            m_acc = {m_acc[6:0], miso_o};
            #80;
            sck_i = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] d);
        ss_n_i = 1'b0;
        spi_bits(d, 8);
        #80;
        ss_n_i = 1'b1;
        #200;
    endtask

    frame_vec_t tbl [4];

    initial begin
        tbl[0] = '{1'b0, 8'h00, 8'hA5, 8'h00, 8'hA5};
        tbl[1] = '{1'b1, 8'h3C, 8'h5A, 8'h3C, 8'h5A};
        tbl[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        tbl[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_ack",  {7'b0, ack_o},  8'h00);
        chk("rst_inta", {7'b0, inta_o}, 8'h00);
        chk("rst_miso", {7'b0, miso_o}, 8'h00);
        chk("rst_dat_o", dat_o, 8'h00);
        rst_i = 1'b0;
        wb_read(2'd0, 8'h00, "rst_ctrl");
        wb_read(2'd1, 8'h00, "rst_status");
        wb_read(2'd2, 8'h00, "rst_rxdata");
        wb_read(2'd3, 8'h00, "txdata_reads_zero");

        wb_write(2'd0, 8'h01);
        wb_read(2'd0, 8'h01, "ctrl_en");

        // Single frames, with and without a queued TX byte
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].do_tx) begin
                wb_write(2'd3, tbl[i].tx);
                wb_read(2'd1, 8'h02, "tbl_txf_set");
            end
            m_acc = 8'h00;
            spi_frame(tbl[i].mosi);
            chk("tbl_miso", m_acc, tbl[i].exp_miso);
            wb_read(2'd1, 8'h01, "tbl_status_rxv");
            wb_read(2'd2, tbl[i].exp_rx, "tbl_rxdata");
            wb_read(2'd1, 8'h00, "tbl_status_cleared");
        end

        // Overrun
        wb_write(2'd0, 8'h03);
        spi_frame(8'h11);
        chk("ovr_inta_rxv", {7'b0, inta_o}, 8'h01);
        spi_frame(8'h22);
        wb_read(2'd1, 8'h05, "ovr_status");
        wb_read(2'd2, 8'h11, "ovr_rxdata_kept");
        chk("ovr_inta_held", {7'b0, inta_o}, 8'h01);
        wb_write(2'd1, 8'h04);
        wb_read(2'd1, 8'h00, "ovr_cleared");
        chk("ovr_inta_clear", {7'b0, inta_o}, 8'h00);
        wb_write(2'd0, 8'h01);

        // Abort by ss_n mid-byte
        ss_n_i = 1'b0;
        spi_bits(8'hFF, 5);
        wb_read(2'd1, 8'h08, "abort_busy");
        ss_n_i = 1'b1;
        #200;
        wb_read(2'd1, 8'h00, "abort_status");
        spi_frame(8'h81);
        wb_read(2'd2, 8'h81, "after_abort_rx");

        // Abort by clearing EN
        ss_n_i = 1'b0;
        spi_bits(8'hFF, 3);
        wb_write(2'd0, 8'h00);
        wb_read(2'd1, 8'h00, "en_abort_idle");
        ss_n_i = 1'b1;
        #200;
        wb_write(2'd0, 8'h01);

        // Multi-byte frame with TX refilled mid-byte
        wb_write(2'd3, 8'hC1);
        m_acc = 8'h00;
        ss_n_i = 1'b0;
        spi_bits(8'h3A, 4);
        wb_read(2'd1, 8'h08, "multi_txf_consumed");
        wb_write(2'd3, 8'h52);
        spi_bits(8'hA0, 4);
        chk("multi_miso0", m_acc, 8'hC1);
        wb_read(2'd2, 8'h3A, "multi_rx0");
        spi_bits(8'h6B, 4);
        wb_write(2'd3, 8'h9D);
        spi_bits(8'hB0, 4);
        chk("multi_miso1", m_acc, 8'h52);
        wb_read(2'd2, 8'h6B, "multi_rx1");
        spi_bits(8'hE4, 8);
        chk("multi_miso2", m_acc, 8'h9D);
        #80;
        ss_n_i = 1'b1;
        #200;
        wb_read(2'd2, 8'hE4, "multi_rx2");
        wb_read(2'd1, 8'h00, "multi_status_end");

        // Reset in the middle of a frame
        wb_write(2'd3, 8'hFF);
        ss_n_i = 1'b0;
        spi_bits(8'hFF, 3);
        chk("pre_rst_miso", {7'b0, miso_o}, 8'h01);
        #3;
        rst_i = 1'b1;
        #30;
        chk("midrst_miso", {7'b0, miso_o}, 8'h00);
        chk("midrst_ack",  {7'b0, ack_o},  8'h00);
        chk("midrst_inta", {7'b0, inta_o}, 8'h00);
        chk("midrst_dat_o", dat_o, 8'h00);
        ss_n_i = 1'b1;
        #30;
        rst_i = 1'b0;
        wb_read(2'd0, 8'h00, "postrst_ctrl");
        wb_read(2'd1, 8'h00, "postrst_status");
        wb_write(2'd0, 8'h01);
        m_acc = 8'hAA;
        spi_frame(8'hF0);
        chk("postrst_miso", m_acc, 8'h00);
        wb_read(2'd2, 8'hF0, "postrst_rx");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
